// File: rtl/shift_reg_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_ctrl
//   Sequencer that serializes a parallel word onto the d/en pins of an
//   MSB-bit shift register, one bit per clock. A word is taken over a
//   valid/ready handshake, shifted out while honouring pause (freeze) and
//   abort (cancel), and a one-cycle done pulse marks each completed frame.
//
//   Optional build macro: SHIFT_REG_CTRL_PARITY_EN
//     When defined, one extra shift cycle carries the even-parity bit
//     (XOR of the captured word) after the MSB data bits.
//
// Parameters
//   MSB        frame width in bits (2..32)
//   LSB_FIRST  0: word bit MSB-1 goes out first; 1: bit 0 goes out first
//   CNT_W      width of frame_count
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   load_valid   requester offers load_data
//   load_data    word to serialize
//   load_ready   controller accepts a word this cycle (IDLE decode)
//   pause        level; freezes shifting while high
//   abort        cancels the frame in progress
//   sr_d, sr_en  serial data / enable to the downstream shift register
//   busy         frame in progress (SHIFT or DONE)
//   done         one-cycle pulse after the last bit of a frame
//   frame_count  completed frames, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module shift_reg_ctrl #(
   parameter int MSB       = 8,
   parameter int LSB_FIRST = 0,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [MSB-1:0]   load_data,
   output logic             load_ready,
   input  logic             pause,
   input  logic             abort,
   output logic             sr_d,
   output logic             sr_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frame_count
);

`ifdef SHIFT_REG_CTRL_PARITY_EN
   localparam int NBITS = MSB + 1;
`else
   localparam int NBITS = MSB;
`endif
   localparam int            BW       = $clog2(NBITS + 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [MSB-1:0]   hold, hold_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic             sr_d_nxt, sr_en_nxt, busy_nxt, done_nxt;
   logic [CNT_W-1:0] frame_count_nxt;

   // Serial bit number idx of word w in transmit order. A one-hot mask is
   // used instead of a variable index so the select works for any MSB.
   function automatic logic bit_at(input logic [MSB-1:0] w, input logic [BW-1:0] idx);
      logic [MSB-1:0] mask;
      logic           b;
      if (LSB_FIRST != 0) mask = MSB'(1) << idx;
      else                mask = {1'b1, {(MSB-1){1'b0}}} >> idx;
      b = |(w & mask);
`ifdef SHIFT_REG_CTRL_PARITY_EN
      if (idx == BW'(MSB)) b = ^w;
`endif
      return b;
   endfunction

   assign load_ready = (state == IDLE);

   // bit_cnt is the index of the bit currently presented on sr_d; it
   // advances on every edge where sr_en is high, because that is the edge
   // on which the downstream register captures the bit.
   always_comb begin
      state_nxt       = state;
      hold_nxt        = hold;
      bit_cnt_nxt     = bit_cnt;
      sr_d_nxt        = sr_d;
      sr_en_nxt       = 1'b0;
      done_nxt        = 1'b0;
      frame_count_nxt = frame_count;
      case (state)
         IDLE: begin
            if (load_valid) begin
               hold_nxt    = load_data;
               bit_cnt_nxt = '0;
               sr_en_nxt   = 1'b1;
               sr_d_nxt    = bit_at(load_data, '0);
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (sr_en) begin
               bit_cnt_nxt = bit_cnt + BW'(1);
               if (bit_cnt == LAST_IDX) begin
                  state_nxt       = DONE;
                  done_nxt        = 1'b1;
                  frame_count_nxt = frame_count + CNT_W'(1);
               end else if (!pause) begin
                  sr_en_nxt = 1'b1;
                  sr_d_nxt  = bit_at(hold, bit_cnt + BW'(1));
               end
            end else if (!pause) begin
               // resume with the bit that was pending when pause took hold
               sr_en_nxt = 1'b1;
               sr_d_nxt  = bit_at(hold, bit_cnt);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hold        <= '0;
         bit_cnt     <= '0;
         sr_d        <= 1'b0;
         sr_en       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_nxt;
         hold        <= hold_nxt;
         bit_cnt     <= bit_cnt_nxt;
         sr_d        <= sr_d_nxt;
         sr_en       <= sr_en_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         frame_count <= frame_count_nxt;
      end
   end

endmodule
